alu_arbiter: RTL and testbench

//   Shares one combinational ALU (add/sub/mul/and/or/nand/nor/xor, 2*DATA_WIDTH result,

---
 rtl/alu_arbiter.sv | 86 ++++++++
 tb/tb_alu_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters with registered operands and a held response
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MUL_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [DATA_WIDTH-1:0]     req0_a,
  input  logic [DATA_WIDTH-1:0]     req0_b,
  input  logic [2:0]                req0_sel,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [DATA_WIDTH-1:0]     req1_a,
  input  logic [DATA_WIDTH-1:0]     req1_b,
  input  logic [2:0]                req1_sel,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [2:0]                alu_sel,
  input  logic [2*DATA_WIDTH-1:0]   alu_out,
  input  logic                      alu_carry,
  input  logic                      alu_zero,
  input  logic                      alu_neg,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [2*DATA_WIDTH-1:0]   rsp_data,
  output logic [2:0]                rsp_flags,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;
  state_t state;
  logic last, id, g1, take;
  logic [2:0] gsel;
  logic [3:0] cnt;
  assign g1 = req1_valid && (!req0_valid || !last);
  assign take = rst_n && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = take && !g1;
  assign req1_ready = take && g1;
  assign gsel = g1 ? req1_sel : req0_sel;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_flags <= '0;
      cnt <= '0;
      last <= 1'b1;
      id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          alu_a <= g1 ? req1_a : req0_a;
          alu_b <= g1 ? req1_b : req0_b;
          alu_sel <= gsel;
          last <= g1;
          id <= g1;
          cnt <= '0;
          state <= (gsel == 3'd2 && MUL_CYCLES > 0) ? WAIT : EXEC;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(MUL_CYCLES - 1)) state <= EXEC;
        end
        EXEC: begin
          rsp_data <= alu_out;
          rsp_flags <= {alu_carry, alu_zero, alu_neg};
          rsp_id <= id;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with a behavioural ALU model on the alu_* side
module tb_alu_arbiter;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0] alu_sel, rsp_flags;
  logic [2*DW-1:0] alu_out, rsp_data;
  logic alu_carry, alu_zero, alu_neg;
  logic [15:0] sa, sb;
  logic [8:0] s9;
  int total = 0, bad = 0, n;
  always #5 clk = ~clk;
  alu_arbiter #(.DATA_WIDTH(DW), .MUL_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy)
  );
  always_comb begin
    sa = {{8{alu_a[7]}}, alu_a};
    sb = {{8{alu_b[7]}}, alu_b};
    s9 = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out = alu_sel == 3'd0 ? sa + sb :
              alu_sel == 3'd1 ? sa - sb :
              alu_sel == 3'd2 ? sa * sb :
              alu_sel == 3'd3 ? sa & sb :
              alu_sel == 3'd4 ? sa | sb :
              alu_sel == 3'd5 ? ~(sa & sb) :
              alu_sel == 3'd6 ? ~(sa | sb) : sa ^ sb;
    alu_carry = alu_sel == 3'd0 ? s9[8] : alu_sel == 3'd1 ? alu_a < alu_b : 1'b0;
    alu_zero = alu_out == '0;
    alu_neg = alu_out[15];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < max) begin
      step();
      cnt++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask
  initial begin
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd3; req0_sel = 3'd0; rsp_ready = 1'b1;
    repeat (2) step();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    rst_n = 1'b1;
    #1;
    chk("t2_ready_T", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    chk("t2_alu_ops", {alu_a, alu_b, alu_sel}, {8'd5, 8'd3, 3'd0});
    chk("t2_busy", busy, 1);
    chk("t2_valid_T1", rsp_valid, 0);
    wait_valid(10, n);
    chk("t2_lat", n, 1);
    chk("t2_data", rsp_data, 16'h0008);
    chk("t2_id", rsp_id, 0);
    chk("t2_flags", rsp_flags, 3'b000);
    step();
    chk("t2_idle", {busy, rsp_valid}, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd3; req0_sel = 3'd2;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_sel = 3'd1;
    #1;
    chk("t3_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    chk("t3_wait_busy", {busy, req1_ready}, 2'b10);
    step();
    chk("t3_valid_T2", rsp_valid, 0);
    wait_valid(10, n);
    chk("t3_mul_lat", n, 1);
    chk("t3_mul_data", rsp_data, 16'h0006);
    chk("t3_mul_id", rsp_id, 0);
    chk("t3_mul_flags", rsp_flags, 3'b000);
    step();
    chk("t3_grant1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_valid(10, n);
    chk("t3_sub_data", rsp_data, 16'hFFFE);
    chk("t3_sub_id", rsp_id, 1);
    chk("t3_sub_flags", rsp_flags, 3'b001);
    step();
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9; req0_sel = 3'd3; rsp_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_sel = 3'd7;
    wait_valid(10, n);
    chk("t4_and_data", rsp_data, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold", {rsp_valid, rsp_id, rsp_flags, rsp_data}, {1'b1, 1'b0, 3'b000, 16'h0001});
      chk("t4_hold_ctl", {req0_ready, req1_ready, busy}, 3'b001);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_idle", {busy, rsp_valid, req1_ready}, 3'b001);
    step();
    req1_valid = 1'b0;
    wait_valid(10, n);
    chk("t4_xor", {rsp_id, rsp_flags, rsp_data}, {1'b1, 3'b001, 16'hFFFF});
    step();
    req0_valid = 1'b1; req0_a = 8'd4; req0_b = 8'd5; req0_sel = 3'd2;
    step();
    req0_valid = 1'b0;
    chk("t5_in_wait", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_reset_idle", {busy, rsp_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1'b1; req0_a = 8'hFC; req0_b = 8'd3; req0_sel = 3'd2;
    step();
    req0_valid = 1'b0;
    wait_valid(10, n);
    chk("t5_mul_lat", n, 2);
    chk("t5_mul", {rsp_id, rsp_flags, rsp_data}, {1'b0, 3'b001, 16'hFFF4});
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_sel = 3'd0;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h7F; req1_sel = 3'd4;
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, n);
      chk("t6_id", rsp_id, k % 2);
      chk("t6_rsp", {rsp_flags, rsp_data}, k % 2 == 0 ? {3'b110, 16'h0000} : {3'b001, 16'hFFFF});
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
    end
    chk("t6_end_idle", {busy, rsp_valid}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
